hazard_unit: RTL and testbench

Data-hazard controller for the five-stage pipeline. It sits beside the decode stage, between the IF/ID register and the ID/EX register. It tracks the destination registers of the instructions in flight in EX, MEM and WB through an internal three-entry scoreboard. From that it drives the forwarding selects for the PA/PB/PD operand muxes, plus the load-use stall controls (PC enable, IF/ID enable, control-unit NOP mux select).

---
 rtl/hazard_unit_if.sv | 33 +++
 rtl/hazard_unit.sv | 87 ++++++++
 tb/tb_hazard_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// Decode-side hazard bus: decoded operand specifiers in, forwarding selects and
// load-use stall controls out.
interface hazard_unit_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_ra;
    logic [REG_W-1:0] id_rb;
    logic [REG_W-1:0] id_rd;
    logic             id_use_a;
    logic             id_use_b;
    logic             id_use_d;
    logic             id_rf_e;
    logic             id_load;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       fwd_d;
    logic             pc_en;
    logic             ifid_en;
    logic             cu_mux_sel;
    logic [CNT_W-1:0] stall_count;

    // Decode stage drives the specifiers and consumes the controls.
    modport master (
        output id_ra, id_rb, id_rd, id_use_a, id_use_b, id_use_d, id_rf_e, id_load,
        input  fwd_a, fwd_b, fwd_d, pc_en, ifid_en, cu_mux_sel, stall_count
    );

    modport slave (
        input  id_ra, id_rb, id_rd, id_use_a, id_use_b, id_use_d, id_rf_e, id_load,
        output fwd_a, fwd_b, fwd_d, pc_en, ifid_en, cu_mux_sel, stall_count
    );
endinterface

// File: rtl/hazard_unit.sv
// Data-hazard controller: three-entry EX/MEM/WB destination scoreboard driving
// operand forwarding selects and the one-cycle load-use stall.
module hazard_unit #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_unit_if.slave  hz
);
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             load;
    } sb_entry_t;

    typedef enum logic [1:0] {
        SRC_RF  = 2'b00,
        SRC_EX  = 2'b01,
        SRC_MEM = 2'b10,
        SRC_WB  = 2'b11
    } fwd_src_e;

    // R15 reads come from the PC path, so it is never a forwarding target.
    localparam logic [REG_W-1:0] PC_REG = REG_W'(15);

    sb_entry_t        sb_ex;
    sb_entry_t        sb_mem;
    sb_entry_t        sb_wb;
    logic [CNT_W-1:0] stall_cnt;
    logic             stall;

    logic ex_a,  ex_b,  ex_d;
    logic mem_a, mem_b, mem_d;
    logic wb_a,  wb_b,  wb_d;

    function automatic logic hit(sb_entry_t e, logic use_op, logic [REG_W-1:0] r);
        return use_op && e.valid && (e.rd == r) && (r != PC_REG);
    endfunction

    function automatic logic [1:0] pick(logic ex_hit, logic mem_hit, logic wb_hit, logic stalled);
        if (ex_hit && !stalled) return SRC_EX;
        if (mem_hit)            return SRC_MEM;
        if (wb_hit)             return SRC_WB;
        return SRC_RF;
    endfunction

    assign ex_a  = hit(sb_ex,  hz.id_use_a, hz.id_ra);
    assign ex_b  = hit(sb_ex,  hz.id_use_b, hz.id_rb);
    assign ex_d  = hit(sb_ex,  hz.id_use_d, hz.id_rd);
    assign mem_a = hit(sb_mem, hz.id_use_a, hz.id_ra);
    assign mem_b = hit(sb_mem, hz.id_use_b, hz.id_rb);
    assign mem_d = hit(sb_mem, hz.id_use_d, hz.id_rd);
    assign wb_a  = hit(sb_wb,  hz.id_use_a, hz.id_ra);
    assign wb_b  = hit(sb_wb,  hz.id_use_b, hz.id_rb);
    assign wb_d  = hit(sb_wb,  hz.id_use_d, hz.id_rd);

    // A load in EX has no result yet; any consumer of it must wait one cycle.
    assign stall = sb_ex.load && (ex_a || ex_b || ex_d);

    assign hz.fwd_a       = pick(ex_a, mem_a, wb_a, stall);
    assign hz.fwd_b       = pick(ex_b, mem_b, wb_b, stall);
    assign hz.fwd_d       = pick(ex_d, mem_d, wb_d, stall);
    assign hz.pc_en       = !stall;
    assign hz.ifid_en     = !stall;
    assign hz.cu_mux_sel  = stall;
    assign hz.stall_count = stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the scoreboard is a handful of flops, not a RAM, so clearing it
            // on reset is cheap and required to forget pre-reset producers.
            sb_ex     <= '0;
            sb_mem    <= '0;
            sb_wb     <= '0;
            stall_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments let the three entries shift in one
            // edge without each stage seeing its predecessor's new value.
            sb_wb  <= sb_mem;
            sb_mem <= sb_ex;
            sb_ex  <= stall ? sb_entry_t'('0) : {hz.id_rf_e, hz.id_rd, hz.id_load};
            if (stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: an instruction-age model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_hazard_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_unit_if #(.REG_W(4), .CNT_W(16)) bif ();
    hazard_unit_if #(.REG_W(4), .CNT_W(2))  sif ();

    hazard_unit #(.REG_W(4), .CNT_W(16)) dut (.clk(clk), .reset(reset), .hz(bif));
    hazard_unit #(.REG_W(4), .CNT_W(2))  dut_sat (.clk(clk), .reset(reset), .hz(sif));

    typedef struct {
        logic [3:0] ra, rb, rd;
        bit ua, ub, ud, rfe, ld;
    } instr_t;

    int n_pass = 0;
    int n_total = 0;
    bit done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: what was issued 1, 2, 3 cycles ago (a stall issues a bubble).
    bit age_v[1:3]  = '{0, 0, 0};
    int age_rd[1:3] = '{0, 0, 0};
    bit age_ld[1:3] = '{0, 0, 0};
    int mdl_cnt16 = 0;
    int mdl_cnt2  = 0;

    function automatic bit uses_age1(bit u, int r);
        return u && r != 15 && age_v[1] && age_rd[1] == r;
    endfunction

    function automatic bit exp_stall();
        return age_ld[1] && (uses_age1(bif.id_use_a, int'(bif.id_ra)) ||
                             uses_age1(bif.id_use_b, int'(bif.id_rb)) ||
                             uses_age1(bif.id_use_d, int'(bif.id_rd)));
    endfunction

    // Forward code is simply the age of the youngest producer of the register.
    function automatic int exp_fwd(bit u, int r, bit s);
        if (!u || r == 15) return 0;
        for (int a = 1; a <= 3; a++) begin
            if (a == 1 && s) continue;
            if (age_v[a] && age_rd[a] == r) return a;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int a = 1; a <= 3; a++) begin
                age_v[a] = 0; age_rd[a] = 0; age_ld[a] = 0;
            end
            mdl_cnt16 = 0;
            mdl_cnt2  = 0;
        end else begin
            bit s;
            s = exp_stall();
            for (int a = 3; a >= 2; a--) begin
                age_v[a] = age_v[a-1]; age_rd[a] = age_rd[a-1]; age_ld[a] = age_ld[a-1];
            end
            age_v[1]  = s ? 1'b0 : bif.id_rf_e;
            age_rd[1] = int'(bif.id_rd);
            age_ld[1] = s ? 1'b0 : bif.id_load;
            if (s) begin
                if (mdl_cnt16 < 65535) mdl_cnt16++;
                if (mdl_cnt2 < 3) mdl_cnt2++;
            end
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            bit s;
            s = exp_stall();
            check("m_fwd_a",  bif.fwd_a, exp_fwd(bif.id_use_a, int'(bif.id_ra), s));
            check("m_fwd_b",  bif.fwd_b, exp_fwd(bif.id_use_b, int'(bif.id_rb), s));
            check("m_fwd_d",  bif.fwd_d, exp_fwd(bif.id_use_d, int'(bif.id_rd), s));
            check("m_pc_en",  bif.pc_en, !s);
            check("m_ifid",   bif.ifid_en, !s);
            check("m_cu_mux", bif.cu_mux_sel, s);
            check("m_cnt16",  bif.stall_count, mdl_cnt16);
            check("m_s_fwd_a", sif.fwd_a, exp_fwd(bif.id_use_a, int'(bif.id_ra), s));
            check("m_s_pc_en", sif.pc_en, !s);
            check("m_cnt2",   sif.stall_count, mdl_cnt2);
        end
    end

    function automatic instr_t mk(int ra, int rb, int rd, bit ua, bit ub, bit ud, bit rfe, bit ld);
        instr_t i;
        i.ra = 4'(ra); i.rb = 4'(rb); i.rd = 4'(rd);
        i.ua = ua; i.ub = ub; i.ud = ud; i.rfe = rfe; i.ld = ld;
        return i;
    endfunction

    function automatic instr_t nop();                return mk(0, 0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic instr_t alu(int rd);          return mk(0, 0, rd, 0, 0, 0, 1, 0); endfunction
    function automatic instr_t ldr(int rd);          return mk(0, 0, rd, 0, 0, 0, 1, 1); endfunction
    function automatic instr_t rd_a(int ra);         return mk(ra, 0, 0, 1, 0, 0, 0, 0); endfunction
    function automatic instr_t rd_b(int rb);         return mk(0, rb, 0, 0, 1, 0, 0, 0); endfunction

    task automatic apply(input instr_t i);
        bif.id_ra = i.ra; bif.id_rb = i.rb; bif.id_rd = i.rd;
        bif.id_use_a = i.ua; bif.id_use_b = i.ub; bif.id_use_d = i.ud;
        bif.id_rf_e = i.rfe; bif.id_load = i.ld;
        sif.id_ra = i.ra; sif.id_rb = i.rb; sif.id_rd = i.rd;
        sif.id_use_a = i.ua; sif.id_use_b = i.ub; sif.id_use_d = i.ud;
        sif.id_rf_e = i.rfe; sif.id_load = i.ld;
    endtask

    // Present an instruction in decode for the next cycle; checks follow at +3.
    task automatic issue(input instr_t i);
        @(posedge clk);
        #1 apply(i);
        #2;
    endtask

    task automatic flush();
        for (int k = 0; k < 3; k++) issue(nop());
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #6 reset = 1'b1;
    endtask

    initial begin
        int exp_gap[4] = '{1, 2, 3, 0};
        int exp_sat[5] = '{1, 2, 3, 3, 3};

        apply(nop());
        #3;
        check("rst_fwd_a", bif.fwd_a, 0);
        check("rst_pc_en", bif.pc_en, 1);
        check("rst_cu_mux", bif.cu_mux_sel, 0);
        check("rst_cnt", bif.stall_count, 0);
        #9 reset = 1'b1;

        // ALU chain: consumer 0..3 cycles after the producer.
        for (int g = 0; g < 4; g++) begin
            flush();
            issue(alu(1));
            for (int k = 0; k < g; k++) issue(nop());
            issue(rd_a(1));
            check($sformatf("alu_gap%0d_fwd_a", g), bif.fwd_a, exp_gap[g]);
            check($sformatf("alu_gap%0d_pc_en", g), bif.pc_en, 1);
        end

        // Load-use: one bubble, then forward from MEM.
        flush();
        issue(ldr(2));
        issue(rd_b(2));
        check("lu_pc_en", bif.pc_en, 0);
        check("lu_ifid", bif.ifid_en, 0);
        check("lu_cu_mux", bif.cu_mux_sel, 1);
        check("lu_fwd_b", bif.fwd_b, 0);
        issue(rd_b(2));
        check("lu2_fwd_b", bif.fwd_b, 2);
        check("lu2_pc_en", bif.pc_en, 1);
        check("lu2_cnt", bif.stall_count, 1);

        // Priority: R3 in WB, MEM and EX at once.
        flush();
        issue(alu(3)); issue(alu(3)); issue(alu(3));
        issue(mk(3, 3, 0, 1, 1, 0, 0, 0));
        check("pri_fwd_a", bif.fwd_a, 1);
        check("pri_fwd_b", bif.fwd_b, 1);
        flush();
        issue(alu(3)); issue(alu(3)); issue(alu(3));
        issue(mk(3, 3, 0, 1, 0, 0, 0, 0));
        check("pri_nob_fwd_a", bif.fwd_a, 1);
        check("pri_nob_fwd_b", bif.fwd_b, 0);

        // R15 is never forwarded and never stalls; store data forwards on D.
        flush();
        issue(alu(15));
        issue(rd_a(15));
        check("r15_fwd_a", bif.fwd_a, 0);
        issue(ldr(15));
        issue(rd_a(15));
        check("r15_ld_fwd_a", bif.fwd_a, 0);
        check("r15_ld_pc_en", bif.pc_en, 1);
        flush();
        issue(alu(4));
        issue(mk(0, 0, 4, 0, 0, 1, 0, 0));
        check("st_fwd_d", bif.fwd_d, 1);

        // Saturation of the narrow counter.
        pulse_reset();
        for (int p = 0; p < 5; p++) begin
            issue(ldr(2));
            issue(rd_b(2));
            issue(rd_b(2));
            check($sformatf("sat%0d_cnt2", p), sif.stall_count, exp_sat[p]);
            check($sformatf("sat%0d_cnt16", p), bif.stall_count, p + 1);
        end

        // Reset asserted while a load-use stall is active.
        flush();
        issue(ldr(5));
        issue(rd_a(5));
        check("mr_pre_pc_en", bif.pc_en, 0);
        #1 reset = 1'b0;
        #2;
        check("mr_fwd_a", bif.fwd_a, 0);
        check("mr_pc_en", bif.pc_en, 1);
        check("mr_ifid", bif.ifid_en, 1);
        check("mr_cu_mux", bif.cu_mux_sel, 0);
        check("mr_cnt", bif.stall_count, 0);
        check("mr_cnt2", sif.stall_count, 0);
        apply(mk(5, 0, 5, 1, 0, 0, 0, 0));
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2;
        check("mr_rel_fwd_a", bif.fwd_a, 0);
        check("mr_rel_pc_en", bif.pc_en, 1);
        check("mr_rel_cnt", bif.stall_count, 0);

        @(posedge clk);
        @(negedge clk);
        #1 done = 1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
